// File: rtl/sum_pkg.sv
// rtl/sum_pkg.sv - shared constants, state encoding and sizing helper for the sum path
//
// Purpose: definitions shared by the 32+32 adder and its BCD conversion stage.
// Ports:   none (package).
package sum_pkg;

  localparam int SUM_W      = 33;
  localparam int BCD_DIGITS = 10;
  localparam logic [3:0] BCD_BLANK = 4'hF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } bcd_state_t;

  // Decimal digits needed to show the largest w-bit unsigned value (w <= 63).
  function automatic int bcd_digits_for(input int w);
    logic [63:0] v;
    int          n;
    v = (64'd1 << w) - 64'd1;
    n = 1;
    while (v > 64'd9) begin
      v = v / 64'd10;
      n = n + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/sum_bin2bcd_if.sv
// rtl/sum_bin2bcd_if.sv - handshake bundle between the adder sum and the BCD converter
//
// Purpose: groups the input-side and output-side valid/ready signals of sum_bin2bcd.
// Ports (signals):
//   in_bin[IN_W]      binary value offered to the converter
//   in_valid/in_ready input handshake
//   bcd[4*DIGITS]     packed BCD result, digit 0 in bits [3:0]
//   out_valid/out_ready output handshake
//   busy              conversion in progress
// Modports: master = producer/consumer side (testbench, adder, display), slave = converter.
interface sum_bin2bcd_if #(
  parameter int IN_W   = sum_pkg::SUM_W,
  parameter int DIGITS = sum_pkg::BCD_DIGITS
);

  logic [IN_W-1:0]     in_bin;
  logic                in_valid;
  logic                in_ready;
  logic [4*DIGITS-1:0] bcd;
  logic                out_valid;
  logic                out_ready;
  logic                busy;

  modport master (
    output in_bin, in_valid, out_ready,
    input  in_ready, bcd, out_valid, busy
  );

  modport slave (
    input  in_bin, in_valid, out_ready,
    output in_ready, bcd, out_valid, busy
  );

endinterface

// File: rtl/sum_bin2bcd_add3.sv
// rtl/sum_bin2bcd_add3.sv - one-digit double-dabble correction (x>=5 ? x+3 : x)
//
// Purpose: combinational BCD digit adjust applied before each left shift.
// Ports:
//   x  input  4  BCD digit before correction
//   y  output 4  corrected digit
module bcd_add3 (
  input  logic [3:0] x,
  output logic [3:0] y
);

  assign y = (x >= 4'd5) ? x + 4'd3 : x;

endmodule

// File: rtl/sum_bin2bcd.sv
// rtl/sum_bin2bcd.sv - iterative binary-to-packed-BCD converter for the adder sum
//
// Purpose: converts an IN_W-bit binary value to DIGITS packed BCD digits with a
//          shift-add-3 engine, one bit per clock, one conversion in flight.
// Optional: define SUM_BCD_BLANK_EN to replace leading zero digits (above digit 0)
//           with the blank code on the transition into DONE.
// Ports:
//   clk  input   sole clock, rising edge
//   rst  input   asynchronous active-high reset
//   bus  slave   sum_bin2bcd_if: in_bin/in_valid/in_ready, bcd/out_valid/out_ready, busy
module sum_bin2bcd
  import sum_pkg::*;
#(
  parameter int IN_W   = SUM_W,
  parameter int DIGITS = BCD_DIGITS
) (
  input  logic          clk,
  input  logic          rst,
  sum_bin2bcd_if.slave  bus
);

  localparam int CNT_W = $clog2(IN_W + 1);
  localparam int BCD_W = 4 * DIGITS;

  // Too few digits would silently truncate the largest sum.
  if (DIGITS < bcd_digits_for(IN_W)) begin : g_digits_check
    $fatal(1, "sum_bin2bcd: DIGITS too small for IN_W");
  end

  bcd_state_t        state, state_nxt;
  logic [IN_W-1:0]   bin_sh;
  logic [BCD_W-1:0]  bcd_sh;
  logic [BCD_W-1:0]  bcd_adj;
  logic [BCD_W-1:0]  bcd_shifted;
  logic [BCD_W-1:0]  bcd_final;
  logic [BCD_W-1:0]  bcd_q;
  logic [CNT_W-1:0]  cnt;

  logic load, step, last;
  logic in_ready_c, busy_c, out_valid_c;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .x (bcd_sh[4*g +: 4]),
      .y (bcd_adj[4*g +: 4])
    );
  end

  // Top bit of the binary shifter enters the units digit.
  assign bcd_shifted = {bcd_adj[BCD_W-2:0], bin_sh[IN_W-1]};

`ifdef SUM_BCD_BLANK_EN
  // Scan from the most significant digit down; zeros before the first
  // nonzero digit are blanked. Digit 0 is always shown.
  always_comb begin
    logic seen;
    bcd_final = bcd_shifted;
    seen      = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (bcd_shifted[4*i +: 4] != 4'd0) begin
        seen = 1'b1;
      end else if (!seen) begin
        bcd_final[4*i +: 4] = BCD_BLANK;
      end
    end
  end
`else
  assign bcd_final = bcd_shifted;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    load        = 1'b0;
    step        = 1'b0;
    last        = 1'b0;
    in_ready_c  = 1'b0;
    busy_c      = 1'b0;
    out_valid_c = 1'b0;
    case (state)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          load      = 1'b1;
          state_nxt = CONVERT;
        end
      end
      CONVERT: begin
        busy_c = 1'b1;
        step   = 1'b1;
        if (cnt == CNT_W'(1)) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // cnt only decrements in CONVERT, where it is at least 1, so it cannot wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_sh <= '0;
      bcd_sh <= '0;
      cnt    <= '0;
      bcd_q  <= '0;
    end else if (load) begin
      bin_sh <= bus.in_bin;
      bcd_sh <= '0;
      cnt    <= CNT_W'(IN_W);
    end else if (step) begin
      bin_sh <= bin_sh << 1;
      bcd_sh <= bcd_shifted;
      cnt    <= cnt - CNT_W'(1);
      if (last) begin
        bcd_q <= bcd_final;
      end
    end
  end

  // in_ready is held low while rst is asserted and rises once it is released.
  assign bus.in_ready  = in_ready_c & ~rst;
  assign bus.busy      = busy_c;
  assign bus.out_valid = out_valid_c;
  assign bus.bcd       = bcd_q;

endmodule

// File: tb/tb_sum_bin2bcd.sv
// tb/tb_sum_bin2bcd.sv - directed self-checking bench for sum_bin2bcd
module tb_sum_bin2bcd;
  import sum_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sum_bin2bcd_if #(.IN_W(SUM_W), .DIGITS(BCD_DIGITS)) bus ();

  sum_bin2bcd #(.IN_W(SUM_W), .DIGITS(BCD_DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

`ifdef SUM_BCD_BLANK_EN
  localparam logic [39:0] E_12811   = 40'hFFFFF12811;
  localparam logic [39:0] E_1000000 = 40'hFFF1000000;
  localparam logic [39:0] E_10021   = 40'hFFFFF10021;
  localparam logic [39:0] E_ZERO    = 40'hFFFFFFFFF0;
`else
  localparam logic [39:0] E_12811   = 40'h0000012811;
  localparam logic [39:0] E_1000000 = 40'h0001000000;
  localparam logic [39:0] E_10021   = 40'h0000010021;
  localparam logic [39:0] E_ZERO    = 40'h0000000000;
`endif
  localparam logic [39:0] E_6456833839 = 40'h6456833839;
  localparam logic [39:0] E_MAX        = 40'h8589934591;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Offer v, wait for the result with out_ready=1, then confirm the drain cycle.
  task automatic run(input string tag, input logic [32:0] v, input logic [39:0] exp,
                     input bit keep_valid);
    int n;
    int rdy_hi;
    bus.in_bin    = v;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_bin   = 33'h1_5555_5555;
    bus.in_valid = keep_valid;
    check({tag, "_busy"}, bus.busy, 1);
    n = 0;
    rdy_hi = 0;
    while (!bus.out_valid && n < 100) begin
      if (bus.in_ready) rdy_hi++;
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"}, n, SUM_W);
    check({tag, "_rdy_in_convert"}, rdy_hi, 0);
    check({tag, "_bcd"}, bus.bcd, exp);
    check({tag, "_rdy_in_done"}, bus.in_ready, 0);
    @(posedge clk); #1;
    check({tag, "_ov_drop"}, bus.out_valid, 0);
    check({tag, "_rdy_back"}, bus.in_ready, 1);
  endtask

  initial begin
    int n;
    rst           = 1'b1;
    bus.in_bin    = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_ov", bus.out_valid, 0);
    check("rst_bcd", bus.bcd, 0);
    check("rst_rdy", bus.in_ready, 0);
    rst = 1'b0;
    #1;
    check("post_rst_rdy", bus.in_ready, 1);

    run("v12811", 33'd12811, E_12811, 1'b0);
    run("b2b_1000000", 33'd1000000, E_1000000, 1'b1);
    run("b2b_10021", 33'd10021, E_10021, 1'b0);
    run("v6456833839", 33'd6456833839, E_6456833839, 1'b0);
    run("vmax", 33'd8589934591, E_MAX, 1'b0);
    run("vzero", 33'd0, E_ZERO, 1'b0);

    // Stall in DONE with out_ready low; in_valid there must not be taken.
    bus.in_bin    = 33'd12811;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("hold_lat", n, SUM_W);
    bus.in_bin   = 33'd5;
    bus.in_valid = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      check("hold_ov", bus.out_valid, 1);
      check("hold_bcd", bus.bcd, E_12811);
      check("hold_rdy", bus.in_ready, 0);
      check("hold_busy", bus.busy, 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_ov", bus.out_valid, 0);
    check("release_rdy", bus.in_ready, 1);
    @(posedge clk); #1;
    check("release_no_accept", bus.busy, 0);

    // Asynchronous reset in the middle of a conversion.
    bus.in_bin   = 33'd999999;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    check("mid_busy", bus.busy, 1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", bus.busy, 0);
    check("arst_ov", bus.out_valid, 0);
    check("arst_bcd", bus.bcd, 0);
    check("arst_rdy", bus.in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("arst_rdy_back", bus.in_ready, 1);
    run("after_rst_1000000", 33'd1000000, E_1000000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
